commit_unit: RTL
================

COMMIT_UNIT -- requirements
Module: commit_unit

Interface
- REQ-001 Parameters (name, default, meaning):
  - WIDTH, 31: data/PC MSB.
  - CONTROL, 5: controlFlow MSB.
  - INDEX, 7: PHT index MSB.
  - ROB, 2: ROB tag MSB.
  - FLUSH_CYCLES, 2: flush pulse length, 1..7.
- REQ-002 Ports (name, direction, width, meaning):
  - clk, in, 1: sole clock, rising edge.
  - globalReset, in, 1: asynchronous, active-high reset.
- REQ-003 Commit bus inputs:
  - validCommit, in, 1.
  - result, in, WIDTH+1.
  - destCommit, in, WIDTH+1: reg index [4:0] or store address.
  - commitInfo, in, 4: {regWrite,memWrite,jump,branch}.
  - oldPC, in, WIDTH+1.
  - targetAddress, in, WIDTH+1.
  - statusSnap, in, WIDTH+1.
  - previousIndex, in, INDEX+1.
  - controlFlow, in, CONTROL+1: {isControl,nextState[1:0],writeBTB,takenBranch,reset}.
  - commitRob, in, ROB+1.
- REQ-004 Outputs:
  - regWrite, out, 1; regDest, out, 5; regData, out, WIDTH+1; regRob, out, ROB+1.
  - storeReq, out, 1; storeAddr, out, WIDTH+1; storeData, out, WIDTH+1; storeAck, in, 1.
  - btbWrite, out, 1; btbPC, out, WIDTH+1; btbTarget, out, WIDTH+1.
  - phtWrite, out, 1; phtIndex, out, INDEX+1; phtState, out, 2; phtTaken, out, 1.
  - redirect, out, 1; redirectPC, out, WIDTH+1.
  - flush, out, 1; statusRestore, out, WIDTH+1.
  - commitStall, out, 1: upstream holds the commit bus while high.

Function
- REQ-005 FSM states: IDLE, STORE, FLUSH. Transitions are evaluated on each rising clk edge.
- REQ-006 A commit is accepted only when validCommit=1, the state is IDLE and commitStall=0. Any other validCommit is ignored with no side effect.
- REQ-007 Accepted commit with regWrite=1 and destCommit[4:0]≠0: the next cycle has a one-cycle pulse regWrite=1, regDest=destCommit[4:0], regData=result, regRob=commitRob. Writes to x0 are suppressed.
- REQ-008 Accepted commit with memWrite=1:
  - Transition to STORE and assert storeReq, storeAddr=destCommit, storeData=result the next cycle.
  - Hold storeReq and the store data stable until the cycle storeAck=1 is sampled, then return to IDLE.
  - commitStall=1 for the whole STORE state.
- REQ-009 storeAck sampled while storeReq=0 shall be ignored. storeAck in the first STORE cycle completes the store in one cycle.
- REQ-010 Accepted commit with isControl=1:
  - The next cycle has a one-cycle pulse phtWrite=branch, phtIndex=previousIndex, phtState=nextState, phtTaken=takenBranch.
  - In the same cycle, btbWrite=writeBTB, btbPC=oldPC, btbTarget=targetAddress.
- REQ-011 Accepted commit with controlFlow.reset=1:
  - Transition to FLUSH. The next cycle has redirect=1 for one cycle, redirectPC=targetAddress, and statusRestore=statusSnap held through FLUSH.
  - flush=1 and commitStall=1 for exactly FLUSH_CYCLES cycles, then return to IDLE.
  - The predictor and register-file writes of that same commit still occur.
- REQ-012 A commit with both memWrite=1 and reset=1 enters STORE first, then FLUSH after storeAck.
- REQ-013 Back-to-back accepted commits in IDLE sustain one commit per cycle with no bubble.
- REQ-014 In IDLE, all pulse outputs (regWrite, btbWrite, phtWrite, redirect, flush, storeReq) shall be 0 when no commit is accepted.

Reset
- REQ-015 globalReset=1 asynchronously forces:
  - state=IDLE;
  - all outputs 0, including statusRestore, redirectPC and the store data/address;
  - the flush counter to 0.
- REQ-016 Reset during STORE drops storeReq immediately, with no completion pulse. Reset during FLUSH terminates flush immediately.
- REQ-017 The first commit is accepted on the first rising edge after globalReset deasserts.

Configuration
- REQ-018 With macro COMMIT_PERF_EN defined, the block adds two 32-bit outputs:
  - retiredCount: +1 per accepted commit.
  - mispredictCount: +1 per FLUSH entry.
  - Both wrap at 2^32 and are cleared by globalReset.
- REQ-019 Without COMMIT_PERF_EN, these ports and counters do not exist and the remaining behaviour is identical.

Verification
- REQ-020 Reg commit regWrite=1, destCommit=5, result=0xDEADBEEF, commitRob=3 -> next cycle regWrite=1, regDest=5, regData=0xDEADBEEF, regRob=3 for one cycle. Same with dest=0 -> no regWrite.
- REQ-021 Store commit addr=0x100, data=0x55, storeAck delayed 3 cycles -> storeReq high 4 cycles with values stable, commitStall high throughout, and a commit presented during the stall is ignored.
- REQ-022 Mispredict commit reset=1, targetAddress=0x40, statusSnap=0xA5, FLUSH_CYCLES=2 -> redirect one cycle with redirectPC=0x40, flush 2 cycles, statusRestore=0xA5, then back to IDLE.
- REQ-023 Four back-to-back branch commits with distinct previousIndex -> four consecutive phtWrite pulses in order with matching phtIndex/phtState.
- REQ-024 globalReset asserted mid-STORE and mid-FLUSH -> all outputs 0 immediately (asynchronously), and the next commit is accepted normally. With COMMIT_PERF_EN, counters read 0 after reset and 5 after five commits.

Source files
------------

// File: rtl/commit_unit.sv
// commit_unit: retires one instruction per cycle from the commit bus.
//
// Purpose
//   Turns an accepted commit into register-file writes, store requests,
//   branch-predictor updates (BTB/PHT) and mispredict recovery (redirect plus
//   a fixed-length flush with status restore). All outputs are registered.
//
// Ports
//   clk, globalReset          clock (rising edge), async active-high reset
//   validCommit ... commitRob commit bus; held by upstream while commitStall=1
//   regWrite/regDest/regData/regRob       one-cycle register write pulse
//   storeReq/storeAddr/storeData/storeAck store handshake (held until ack)
//   btbWrite/btbPC/btbTarget              one-cycle BTB update pulse
//   phtWrite/phtIndex/phtState/phtTaken   one-cycle PHT update pulse
//   redirect/redirectPC                   one-cycle fetch redirect
//   flush/statusRestore                   flush window and restored status
//   commitStall                           high while in STORE or FLUSH
//
// Configuration
//   COMMIT_PERF_EN: adds retiredCount (accepted commits) and mispredictCount
//   (FLUSH entries), 32-bit wrapping counters cleared by globalReset.
module commit_unit #(
  parameter int unsigned WIDTH        = 31,
  parameter int unsigned CONTROL      = 5,
  parameter int unsigned INDEX        = 7,
  parameter int unsigned ROB          = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               globalReset,
  // Commit bus
  input  logic               validCommit,
  input  logic [WIDTH:0]     result,
  input  logic [WIDTH:0]     destCommit,
  input  logic [3:0]         commitInfo,
  input  logic [WIDTH:0]     oldPC,
  input  logic [WIDTH:0]     targetAddress,
  input  logic [WIDTH:0]     statusSnap,
  input  logic [INDEX:0]     previousIndex,
  input  logic [CONTROL:0]   controlFlow,
  input  logic [ROB:0]       commitRob,
  // Register file
  output logic               regWrite,
  output logic [4:0]         regDest,
  output logic [WIDTH:0]     regData,
  output logic [ROB:0]       regRob,
  // Store port
  output logic               storeReq,
  output logic [WIDTH:0]     storeAddr,
  output logic [WIDTH:0]     storeData,
  input  logic               storeAck,
  // Branch predictor
  output logic               btbWrite,
  output logic [WIDTH:0]     btbPC,
  output logic [WIDTH:0]     btbTarget,
  output logic               phtWrite,
  output logic [INDEX:0]     phtIndex,
  output logic [1:0]         phtState,
  output logic               phtTaken,
  // Recovery
  output logic               redirect,
  output logic [WIDTH:0]     redirectPC,
  output logic               flush,
  output logic [WIDTH:0]     statusRestore,
  output logic               commitStall
`ifdef COMMIT_PERF_EN
  ,
  output logic [31:0]        retiredCount,
  output logic [31:0]        mispredictCount
`endif
);

  typedef enum logic [1:0] {StIdle, StStore, StFlush} state_e;

  // Counter holds remaining flush cycles minus one; entry loads this value.
  localparam logic [2:0] FlushLast = 3'(FLUSH_CYCLES - 1);

  // Commit bus field decode
  logic info_reg_write, info_mem_write, info_branch;
  logic cf_is_control, cf_write_btb, cf_taken, cf_reset;
  logic [1:0] cf_next_state;
  logic unused_jump;

  assign info_reg_write = commitInfo[3];
  assign info_mem_write = commitInfo[2];
  assign unused_jump    = commitInfo[1];
  assign info_branch    = commitInfo[0];
  assign cf_is_control  = controlFlow[5];
  assign cf_next_state  = controlFlow[4:3];
  assign cf_write_btb   = controlFlow[2];
  assign cf_taken       = controlFlow[1];
  assign cf_reset       = controlFlow[0];

  state_e         state_q, state_d;
  logic [2:0]     flush_cnt_q, flush_cnt_d;
  logic           flush_pend_q, flush_pend_d;
  logic           reg_write_q, reg_write_d;
  logic [4:0]     reg_dest_q, reg_dest_d;
  logic [WIDTH:0] reg_data_q, reg_data_d;
  logic [ROB:0]   reg_rob_q, reg_rob_d;
  logic           store_req_q, store_req_d;
  logic [WIDTH:0] store_addr_q, store_addr_d;
  logic [WIDTH:0] store_data_q, store_data_d;
  logic           btb_write_q, btb_write_d;
  logic [WIDTH:0] btb_pc_q, btb_pc_d;
  logic [WIDTH:0] btb_target_q, btb_target_d;
  logic           pht_write_q, pht_write_d;
  logic [INDEX:0] pht_index_q, pht_index_d;
  logic [1:0]     pht_state_q, pht_state_d;
  logic           pht_taken_q, pht_taken_d;
  logic           redirect_q, redirect_d;
  logic [WIDTH:0] redirect_pc_q, redirect_pc_d;
  logic           flush_q, flush_d;
  logic [WIDTH:0] status_restore_q, status_restore_d;

  logic commit_stall;
  logic accept;
  logic enter_flush;

  assign commit_stall = (state_q != StIdle);
  assign accept       = validCommit && (state_q == StIdle) && !commit_stall;

  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    flush_pend_d     = flush_pend_q;
    reg_write_d      = 1'b0;
    reg_dest_d       = reg_dest_q;
    reg_data_d       = reg_data_q;
    reg_rob_d        = reg_rob_q;
    store_req_d      = store_req_q;
    store_addr_d     = store_addr_q;
    store_data_d     = store_data_q;
    btb_write_d      = 1'b0;
    btb_pc_d         = btb_pc_q;
    btb_target_d     = btb_target_q;
    pht_write_d      = 1'b0;
    pht_index_d      = pht_index_q;
    pht_state_d      = pht_state_q;
    pht_taken_d      = pht_taken_q;
    redirect_d       = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    status_restore_d = status_restore_q;
    enter_flush      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // x0 is hardwired to zero, so writes to it are dropped.
          if (info_reg_write && (destCommit[4:0] != 5'd0)) begin
            reg_write_d = 1'b1;
            reg_dest_d  = destCommit[4:0];
            reg_data_d  = result;
            reg_rob_d   = commitRob;
          end
          if (cf_is_control) begin
            pht_write_d  = info_branch;
            pht_index_d  = previousIndex;
            pht_state_d  = cf_next_state;
            pht_taken_d  = cf_taken;
            btb_write_d  = cf_write_btb;
            btb_pc_d     = oldPC;
            btb_target_d = targetAddress;
          end
          // Recovery values are captured now even if the flush waits for a store.
          if (cf_reset) begin
            redirect_pc_d    = targetAddress;
            status_restore_d = statusSnap;
          end
          if (info_mem_write) begin
            state_d      = StStore;
            store_req_d  = 1'b1;
            store_addr_d = destCommit;
            store_data_d = result;
            flush_pend_d = cf_reset;
          end else if (cf_reset) begin
            enter_flush = 1'b1;
          end
        end
      end
      StStore: begin
        if (storeAck) begin
          store_req_d = 1'b0;
          if (flush_pend_q) begin
            flush_pend_d = 1'b0;
            enter_flush  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StFlush: begin
        if (flush_cnt_q == 3'd0) begin
          state_d = StIdle;
          flush_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (enter_flush) begin
      state_d     = StFlush;
      redirect_d  = 1'b1;
      flush_d     = 1'b1;
      flush_cnt_d = FlushLast;
    end
  end

  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      state_q          <= StIdle;
      flush_cnt_q      <= '0;
      flush_pend_q     <= 1'b0;
      reg_write_q      <= 1'b0;
      reg_dest_q       <= '0;
      reg_data_q       <= '0;
      reg_rob_q        <= '0;
      store_req_q      <= 1'b0;
      store_addr_q     <= '0;
      store_data_q     <= '0;
      btb_write_q      <= 1'b0;
      btb_pc_q         <= '0;
      btb_target_q     <= '0;
      pht_write_q      <= 1'b0;
      pht_index_q      <= '0;
      pht_state_q      <= '0;
      pht_taken_q      <= 1'b0;
      redirect_q       <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      status_restore_q <= '0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      flush_pend_q     <= flush_pend_d;
      reg_write_q      <= reg_write_d;
      reg_dest_q       <= reg_dest_d;
      reg_data_q       <= reg_data_d;
      reg_rob_q        <= reg_rob_d;
      store_req_q      <= store_req_d;
      store_addr_q     <= store_addr_d;
      store_data_q     <= store_data_d;
      btb_write_q      <= btb_write_d;
      btb_pc_q         <= btb_pc_d;
      btb_target_q     <= btb_target_d;
      pht_write_q      <= pht_write_d;
      pht_index_q      <= pht_index_d;
      pht_state_q      <= pht_state_d;
      pht_taken_q      <= pht_taken_d;
      redirect_q       <= redirect_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      status_restore_q <= status_restore_d;
    end
  end

  assign regWrite      = reg_write_q;
  assign regDest       = reg_dest_q;
  assign regData       = reg_data_q;
  assign regRob        = reg_rob_q;
  assign storeReq      = store_req_q;
  assign storeAddr     = store_addr_q;
  assign storeData     = store_data_q;
  assign btbWrite      = btb_write_q;
  assign btbPC         = btb_pc_q;
  assign btbTarget     = btb_target_q;
  assign phtWrite      = pht_write_q;
  assign phtIndex      = pht_index_q;
  assign phtState      = pht_state_q;
  assign phtTaken      = pht_taken_q;
  assign redirect      = redirect_q;
  assign redirectPC    = redirect_pc_q;
  assign flush         = flush_q;
  assign statusRestore = status_restore_q;
  assign commitStall   = commit_stall;

`ifdef COMMIT_PERF_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] mispredict_q, mispredict_d;

  always_comb begin
    retired_d    = retired_q + (accept ? 32'd1 : 32'd0);
    mispredict_d = mispredict_q + (enter_flush ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge globalReset) begin
    if (globalReset) begin
      retired_q    <= '0;
      mispredict_q <= '0;
    end else begin
      retired_q    <= retired_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign retiredCount    = retired_q;
  assign mispredictCount = mispredict_q;
`endif

endmodule
